control: RTL and testbench

- Free-running timing/strobe generator for the signal-processing datapath.
- Divides the system clock by 2^NB_COUNT with an NB_COUNT-bit wrap-around counter.
- Emits a single-cycle registered `o_valid` strobe once per counter period.
- Downstream blocks (PRBS, filters, decimators) use `o_valid` as their clock enable / sample strobe.

---
 rtl/control.sv | 35 +++
 tb/tb_control.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/control.sv
// rtl/control.sv - free-running sample strobe generator, one pulse per 2^NB_COUNT clocks
`timescale 1ns/1ps

module control #(
  parameter int NB_COUNT = 2
) (
  input  logic clock,
  input  logic i_reset,
  output logic o_valid
);

  localparam logic [NB_COUNT-1:0] COUNT_LAST = {NB_COUNT{1'b1}};
  localparam logic [NB_COUNT-1:0] COUNT_STEP = NB_COUNT'(1);

  logic [NB_COUNT-1:0] count;

  // Wrap-around period counter; the top value rolls straight back to zero
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else begin
      count <= count + COUNT_STEP;
    end
  end

  // Registered strobe, set on the edge where the counter wraps so consumers see a clean flop output
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= (count == COUNT_LAST);
    end
  end

endmodule

// File: tb/tb_control.sv
// tb/tb_control.sv - directed vector bench for the control strobe generator
`timescale 1ns/1ps

module tb_control;

  logic clock = 1'b0;
  logic i_reset = 1'b1;
  logic v1, v2, v4;

  int n_cmp = 0;
  int n_err = 0;

  control #(.NB_COUNT(1)) u1 (.clock(clock), .i_reset(i_reset), .o_valid(v1));
  control #(.NB_COUNT(2)) u2 (.clock(clock), .i_reset(i_reset), .o_valid(v2));
  control #(.NB_COUNT(4)) u4 (.clock(clock), .i_reset(i_reset), .o_valid(v4));

  always #5 clock = ~clock;

  typedef struct {
    int   edge_num;
    logic e1;
    logic e2;
    logic e4;
  } vec_t;

  // Expected strobe after edges 1..20 following release, leftmost bit is edge 1
  localparam logic [19:0] PAT1 = 20'b01010101010101010101;
  localparam logic [19:0] PAT2 = 20'b00010001000100010001;
  localparam logic [19:0] PAT4 = 20'b00000000000000010000;

  vec_t vecs [20];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int pulses1, pulses2, pulses4, bad_gap, last2, hi_run;
    int waited;
    bit seen;

    for (int i = 0; i < 20; i++) begin
      vecs[i].edge_num = i + 1;
      vecs[i].e1 = PAT1[19-i];
      vecs[i].e2 = PAT2[19-i];
      vecs[i].e4 = PAT4[19-i];
    end

    // Power-on reset held 100 ns: strobes low and counter parked at zero
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("reset_v1", int'(v1), 0);
      check("reset_v2", int'(v2), 0);
      check("reset_v4", int'(v4), 0);
      check("reset_count2", int'(u2.count), 0);
    end

    // Release between edges and walk the first 20 edges against the vector table
    i_reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_v1", vecs[i].edge_num), int'(v1), int'(vecs[i].e1));
      check($sformatf("vec%0d_v2", vecs[i].edge_num), int'(v2), int'(vecs[i].e2));
      check($sformatf("vec%0d_v4", vecs[i].edge_num), int'(v4), int'(vecs[i].e4));
      if (vecs[i].edge_num == 16) check("count4_wrap", int'(u4.count), 0);
      if (vecs[i].edge_num == 3)  check("count2_at3", int'(u2.count), 3);
    end

    // Periodicity over 10 us: pulse counts and spacing
    pulses1 = 0; pulses2 = 0; pulses4 = 0; bad_gap = 0; last2 = 20; hi_run = 0;
    for (int n = 21; n <= 1020; n++) begin
      @(posedge clock);
      #1;
      if (v1) pulses1++;
      if (v4) pulses4++;
      if (v2) begin
        pulses2++;
        hi_run++;
        if (n - last2 != 4) bad_gap++;
        last2 = n;
      end else begin
        hi_run = 0;
      end
      if (hi_run > 1) bad_gap++;
      if ((n % 4) == 1) begin
        if (int'(u2.count) != 1) bad_gap++;
      end
    end
    check("period_pulses1", pulses1, 500);
    check("period_pulses2", pulses2, 250);
    check("period_pulses4", pulses4, 62);
    check("period_bad_gap2", bad_gap, 0);

    // Bring u2 to a strobe, then assert reset mid-cycle and check it clears without a clock edge
    waited = 0;
    seen = 0;
    while (!seen && waited < 10) begin
      @(posedge clock);
      #1;
      waited++;
      if (v2) seen = 1;
    end
    check("midop_strobe_seen", int'(seen), 1);
    #1;
    i_reset = 1'b1;
    #1;
    check("midop_async_v2", int'(v2), 0);
    check("midop_async_count2", int'(u2.count), 0);
    check("midop_async_v1", int'(v1), 0);
    @(negedge clock);
    @(negedge clock);
    check("midop_hold_v2", int'(v2), 0);
    i_reset = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clock);
      #1;
      check($sformatf("midop_rel_e%0d_v2", n), int'(v2), ((n % 4) == 0) ? 1 : 0);
    end

    // Release just after a rising edge: that edge must not count
    @(negedge clock);
    i_reset = 1'b1;
    @(negedge clock);
    @(posedge clock);
    #0.001;
    i_reset = 1'b0;
    check("align_count2", int'(u2.count), 0);
    for (int n = 1; n <= 6; n++) begin
      @(posedge clock);
      #1;
      check($sformatf("align_e%0d_v2", n), int'(v2), (n == 4) ? 1 : 0);
      check($sformatf("align_e%0d_v1", n), int'(v1), ((n % 2) == 0) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded bound, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
